note_lane_scheduler: RTL

- Owns and sequences the four 16-bit note channels that the hit-judgment logic reads.
- Spawns notes from a chart stream using a valid/ready handshake, and advances every lane one position per game step.
- Clears notes that are hit, and counts notes that fall off the end as misses.
- Drives `run` to the judgment logic and reports game state (IDLE / PLAY / PAUSE / DRAIN / DONE).

---
 rtl/game_pkg.sv | 54 +++++
 rtl/step_timer.sv | 37 +++
 rtl/note_lane_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the note lane scheduler and the hit-judgment logic:
// lane geometry, judgment window bit positions, state and judgment encodings.
package game_pkg;

  localparam int LANES      = 4;
  localparam int LANE_DEPTH = 16;

  localparam int GREAT_BIT  = 15;
  localparam int NICE_BIT   = 14;
  localparam int NORMAL_BIT = 13;
  localparam int BAD_BIT    = 12;

  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_PLAY  = 3'd1,
    GS_PAUSE = 3'd2,
    GS_DRAIN = 3'd3,
    GS_DONE  = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    JUDGE_BAD    = 2'd0,
    JUDGE_NORMAL = 2'd1,
    JUDGE_NICE   = 2'd2,
    JUDGE_GREAT  = 2'd3
  } judge_t;

  // Mask of the judgment window positions within one lane.
  function automatic logic [LANE_DEPTH-1:0] window_mask();
    logic [LANE_DEPTH-1:0] m;
    m             = '0;
    m[GREAT_BIT]  = 1'b1;
    m[NICE_BIT]   = 1'b1;
    m[NORMAL_BIT] = 1'b1;
    m[BAD_BIT]    = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] popcount4(input logic [LANES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'b000000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/step_timer.sv
// Game-step divider: counts enabled cycles and flags the last cycle of each
// TICK_DIV-cycle step; holds while disabled so a paused step resumes in place.
module step_timer #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step_due
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;

  assign step_due = en && (count_r == LAST);

  // Divider counter: clear has priority, wraps after the step cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/note_lane_scheduler.sv
// Owns the four note lanes: spawns chart entries, advances lanes each game step,
// clears hit windows, counts misses and sequences the game state.
module note_lane_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic                              system_clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              pause,
  input  logic                              chart_valid,
  input  logic [LANES-1:0]                  chart_lanes,
  input  logic                              chart_last,
  output logic                              chart_ready,
  input  logic [LANES-1:0]                  hit_clear,
  output logic [LANES-1:0][LANE_DEPTH-1:0]  channel,
  output logic                              run,
  output logic                              step_pulse,
  output logic                              miss_pulse,
  output logic [7:0]                        miss_count,
  output logic [2:0]                        game_state,
  output logic                              done
);

  localparam logic [LANE_DEPTH-1:0] WINDOW = window_mask();

  game_state_t state_r, state_s, resume_r, resume_s;
  logic [LANES-1:0][LANE_DEPTH-1:0] lanes_r, lanes_s, hit_s;
  logic [LANES-1:0] missed_s;
  logic [7:0] miss_count_r, miss_count_s;
  logic step_pulse_r, miss_pulse_r, run_r, done_r;
  logic playing_s, active_s, start_ok_s, step_due_s, transfer_s;

  assign playing_s  = (state_r == GS_PLAY) || (state_r == GS_DRAIN);
  assign active_s   = playing_s && !pause;
  assign start_ok_s = start && ((state_r == GS_IDLE) || (state_r == GS_DONE));

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk      (system_clk),
    .rst_n    (rst_n),
    .en       (active_s),
    .clr      (start_ok_s),
    .step_due (step_due_s)
  );

  assign chart_ready = step_due_s && (state_r == GS_PLAY);
  assign transfer_s  = chart_valid && chart_ready;

  // Lane datapath: hit clear, miss detect, shift, spawn, then saturating miss count.
  always_comb begin
    hit_s        = lanes_r;
    lanes_s      = lanes_r;
    missed_s     = '0;
    miss_count_s = miss_count_r;
    for (int i = 0; i < LANES; i++) begin
      if (active_s && hit_clear[i]) begin
        hit_s[i] = lanes_r[i] & ~WINDOW;
      end else begin
        hit_s[i] = lanes_r[i];
      end
      missed_s[i] = hit_s[i][LANE_DEPTH-1];
      if (step_due_s) begin
        lanes_s[i] = {hit_s[i][LANE_DEPTH-2:0], 1'b0};
        // A near-spawn entry blocks the new note so the window never holds two.
        if (transfer_s && chart_lanes[i] && (lanes_r[i][3:0] == 4'b0000)) begin
          lanes_s[i][0] = 1'b1;
        end else begin
          lanes_s[i][0] = 1'b0;
        end
      end else begin
        lanes_s[i] = hit_s[i];
      end
    end
    if (step_due_s) begin
      miss_count_s = sat_add8(miss_count_r, popcount4(missed_s));
    end else begin
      miss_count_s = miss_count_r;
    end
    if (start_ok_s) begin
      lanes_s      = '0;
      miss_count_s = 8'd0;
    end else begin
      miss_count_s = miss_count_s;
    end
  end

  // Game state next-state logic; pause takes priority over any step activity.
  always_comb begin
    state_s  = state_r;
    resume_s = resume_r;
    case (state_r)
      GS_IDLE, GS_DONE: begin
        if (start) begin
          state_s = GS_PLAY;
        end else begin
          state_s = state_r;
        end
      end
      GS_PLAY: begin
        if (pause) begin
          state_s  = GS_PAUSE;
          resume_s = GS_PLAY;
        end else if (transfer_s && chart_last) begin
          state_s = GS_DRAIN;
        end else begin
          state_s = GS_PLAY;
        end
      end
      GS_DRAIN: begin
        if (pause) begin
          state_s  = GS_PAUSE;
          resume_s = GS_DRAIN;
        end else if (step_due_s && (lanes_s == '0)) begin
          state_s = GS_DONE;
        end else begin
          state_s = GS_DRAIN;
        end
      end
      GS_PAUSE: begin
        if (!pause) begin
          state_s = resume_r;
        end else begin
          state_s = GS_PAUSE;
        end
      end
      default: begin
        state_s  = GS_IDLE;
        resume_s = GS_PLAY;
      end
    endcase
  end

  // State, lane and status registers.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= GS_IDLE;
      resume_r     <= GS_PLAY;
      lanes_r      <= '0;
      miss_count_r <= 8'd0;
      step_pulse_r <= 1'b0;
      miss_pulse_r <= 1'b0;
      run_r        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      resume_r     <= resume_s;
      lanes_r      <= lanes_s;
      miss_count_r <= miss_count_s;
      step_pulse_r <= step_due_s;
      miss_pulse_r <= step_due_s && (missed_s != '0);
      run_r        <= (state_s == GS_PLAY) || (state_s == GS_DRAIN);
      done_r       <= (state_s == GS_DONE);
    end
  end

  assign channel    = lanes_r;
  assign miss_count = miss_count_r;
  assign step_pulse = step_pulse_r;
  assign miss_pulse = miss_pulse_r;
  assign run        = run_r;
  assign done       = done_r;
  assign game_state = state_r;

endmodule
